// File: rtl/led_p2s_ctrl_pkg.sv
// Shared definitions for the LED parallel-to-serial sequencer:
// the state encoding and the default frame geometry.
package led_p2s_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_CLK_DIV = 2;

endpackage

// File: rtl/led_p2s_ctrl_p2s_shreg.sv
// Parallel-load, left-shifting register feeding the LED serial data pin.
// Load wins over shift; the vacated LSB fills with zero.
module p2s_shreg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Shift register state: load, shift or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {W{1'b0}};
    end else if (load) begin
      q_r <= d;
    end else if (shift) begin
      q_r <= {q_r[W-2:0], 1'b0};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/led_p2s_ctrl.sv
// LED frame sequencer: captures a pattern on start, clocks it out MSB-first
// on a divided serial clock, then strobes the driver output latch.
module led_p2s_ctrl
  import led_p2s_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] par_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              sdata,
  output logic              latch
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_e            state_r, state_nxt_s;
  logic [DIV_W-1:0]  div_cnt_r, div_nxt_s;
  logic [BIT_W-1:0]  bit_cnt_r, bit_nxt_s;
  logic              load_s, shift_s, div_end_s, done_nxt_s;
  logic              busy_r, done_r, sclk_r, latch_r;
  logic [DATA_W-1:0] shreg_q_s;

  assign div_end_s = (div_cnt_r == DIV_LAST);

  // Next-state, counter and shift-control decode.
  always_comb begin
    state_nxt_s = state_r;
    div_nxt_s   = div_cnt_r;
    bit_nxt_s   = bit_cnt_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SHIFT_LO;
          div_nxt_s   = {DIV_W{1'b0}};
          bit_nxt_s   = {BIT_W{1'b0}};
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT_LO: begin
        if (div_end_s) begin
          state_nxt_s = SHIFT_HI;
          div_nxt_s   = {DIV_W{1'b0}};
        end else begin
          div_nxt_s   = div_cnt_r + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_end_s) begin
          div_nxt_s = {DIV_W{1'b0}};
          if (bit_cnt_r == BIT_LAST) begin
            state_nxt_s = LATCH;
          end else begin
            // shifting on the sclk fall keeps sdata stable for the whole high phase
            state_nxt_s = SHIFT_LO;
            bit_nxt_s   = bit_cnt_r + BIT_W'(1);
            shift_s     = 1'b1;
          end
        end else begin
          div_nxt_s = div_cnt_r + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_end_s) begin
          state_nxt_s = IDLE;
          div_nxt_s   = {DIV_W{1'b0}};
        end else begin
          div_nxt_s   = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        div_nxt_s   = {DIV_W{1'b0}};
        bit_nxt_s   = {BIT_W{1'b0}};
      end
    endcase
    done_nxt_s = (state_r == LATCH) && (state_nxt_s == IDLE);
  end

  // State, counters and pin registers; pins are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sclk_r    <= 1'b0;
      latch_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      div_cnt_r <= div_nxt_s;
      bit_cnt_r <= bit_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
      done_r    <= done_nxt_s;
      sclk_r    <= (state_nxt_s == SHIFT_HI);
      latch_r   <= (state_nxt_s == LATCH);
    end
  end

  p2s_shreg #(.W(DATA_W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load_s),
    .shift (shift_s),
    .d     (par_data),
    .q     (shreg_q_s)
  );

  assign busy  = busy_r;
  assign done  = done_r;
  assign sclk  = sclk_r;
  assign latch = latch_r;
  assign sdata = shreg_q_s[DATA_W-1];

endmodule
